fp_to_fixed: RTL and testbench

//  Converts one IEEE-style half-float into a signed fixed-point word over a valid/ready handshake.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_to_fixed_if.sv | 25 ++
 rtl/fp_unpack.sv | 24 ++
 rtl/fp_to_fixed.sv | 128 ++++++++++++
 tb/tb_fp_to_fixed.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared half-float definitions for the float datapath and the blocks that consume its results.
package fp_pkg;

   localparam int FLOATSIZE     = 16;
   localparam int EXPONENTSIZE  = 5;
   localparam int EXPONENT_BIAS = 15;
   localparam int SIGSIZE       = FLOATSIZE - EXPONENTSIZE - 1;
   localparam int FIXEDSIZE     = 16;
   localparam int FRACBITS      = 8;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

   typedef struct packed {
      logic                    sign;
      logic [EXPONENTSIZE-1:0] exp;
      logic [SIGSIZE-1:0]      sig;
   } fp16_t;

endpackage

// File: rtl/fp_to_fixed_if.sv
// Valid/ready float-in, fixed-out handshake bundle; slave is the converter's view.
interface fp_to_fixed_if
   import fp_pkg::*;
#(
   parameter int FLOATSIZE = fp_pkg::FLOATSIZE,
   parameter int FIXEDSIZE = fp_pkg::FIXEDSIZE
);
   logic                 in_valid;
   logic                 in_ready;
   logic [FLOATSIZE-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [FIXEDSIZE-1:0] out_data;
   logic                 out_overflow;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_overflow
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_overflow
   );
endinterface

// File: rtl/fp_unpack.sv
// Combinational field split of a float word with zero/denormal and inf/NaN classification.
module fp_unpack
   import fp_pkg::*;
#(
   parameter int FLOATSIZE    = fp_pkg::FLOATSIZE,
   parameter int EXPONENTSIZE = fp_pkg::EXPONENTSIZE
) (
   input  logic [FLOATSIZE-1:0]              fp,
   output logic                              sign,
   output logic [EXPONENTSIZE-1:0]           exp,
   output logic [FLOATSIZE-EXPONENTSIZE-2:0] sig,
   output logic                              is_zero,
   output logic                              is_special
);

   always_comb begin
      sign       = fp[FLOATSIZE-1];
      exp        = fp[FLOATSIZE-2 -: EXPONENTSIZE];
      sig        = fp[FLOATSIZE-EXPONENTSIZE-2:0];
      is_zero    = (exp == '0);
      is_special = (exp == '1);
   end

endmodule

// File: rtl/fp_to_fixed.sv
// Half-float to signed fixed-point converter; iterative one-bit-per-cycle shifter behind valid/ready.
module fp_to_fixed
   import fp_pkg::*;
#(
   parameter int FLOATSIZE     = fp_pkg::FLOATSIZE,
   parameter int EXPONENTSIZE  = fp_pkg::EXPONENTSIZE,
   parameter int EXPONENT_BIAS = fp_pkg::EXPONENT_BIAS,
   parameter int FIXEDSIZE     = fp_pkg::FIXEDSIZE,
   parameter int FRACBITS      = fp_pkg::FRACBITS
) (
   input logic          clk,
   input logic          rst_n,
   fp_to_fixed_if.slave bus
);

   localparam int SIG_W = FLOATSIZE - EXPONENTSIZE - 1;
   localparam int SW    = 16;
   localparam int CW    = $clog2(FIXEDSIZE + 1);

   // s = exp - S_OFS; beyond S_MAX a left shift would push the hidden bit into the sign bit.
   localparam logic signed [SW-1:0] S_OFS = SW'(EXPONENT_BIAS + SIG_W - FRACBITS);
   localparam logic signed [SW-1:0] S_MAX = SW'(FIXEDSIZE - 1 - (SIG_W + 1));
   localparam logic signed [SW-1:0] S_MIN = SW'(-(SIG_W + 1));

   localparam logic [FIXEDSIZE-1:0] POS_MAX = {1'b0, {(FIXEDSIZE-1){1'b1}}};
   localparam logic [FIXEDSIZE-1:0] NEG_MAX = {1'b1, {(FIXEDSIZE-1){1'b0}}};

   logic                    u_sign;
   logic [EXPONENTSIZE-1:0] u_exp;
   logic [SIG_W-1:0]        u_sig;
   logic                    u_zero;
   logic                    u_special;

   fp_unpack #(
      .FLOATSIZE    (FLOATSIZE),
      .EXPONENTSIZE (EXPONENTSIZE)
   ) u_unpack (
      .fp         (bus.in_data),
      .sign       (u_sign),
      .exp        (u_exp),
      .sig        (u_sig),
      .is_zero    (u_zero),
      .is_special (u_special)
   );

   conv_state_t            state;
   logic                   sign_q;
   logic                   left_q;
   logic [FIXEDSIZE-1:0]   mag_q;
   logic [CW-1:0]          cnt_q;

   logic signed [SW-1:0]   s_val;
   logic signed [SW-1:0]   abs_s;
   logic [FIXEDSIZE-1:0]   init_mag;
   logic [FIXEDSIZE-1:0]   mag_next;

   function automatic logic [FIXEDSIZE-1:0] apply_sign(input logic s, input logic [FIXEDSIZE-1:0] m);
      return s ? -m : m;
   endfunction

   always_comb begin
      s_val    = $signed(SW'(u_exp)) - S_OFS;
      abs_s    = s_val[SW-1] ? -s_val : s_val;
      init_mag = FIXEDSIZE'({1'b1, u_sig});
      mag_next = left_q ? (mag_q << 1) : (mag_q >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         sign_q           <= 1'b0;
         left_q           <= 1'b0;
         mag_q            <= '0;
         cnt_q            <= '0;
         bus.in_ready     <= 1'b1;
         bus.out_valid    <= 1'b0;
         bus.out_data     <= '0;
         bus.out_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sign_q           <= u_sign;
                  left_q           <= !s_val[SW-1];
                  mag_q            <= init_mag;
                  cnt_q            <= CW'(abs_s);
                  bus.in_ready     <= 1'b0;
                  bus.out_overflow <= 1'b0;
                  if (u_zero || (!u_special && s_val <= S_MIN)) begin
                     bus.out_data  <= '0;
                     bus.out_valid <= 1'b1;
                     state         <= DONE;
                  end else if (u_special || s_val > S_MAX) begin
                     bus.out_data     <= u_sign ? NEG_MAX : POS_MAX;
                     bus.out_overflow <= 1'b1;
                     bus.out_valid    <= 1'b1;
                     state            <= DONE;
                  end else if (s_val == '0) begin
                     bus.out_data  <= apply_sign(u_sign, init_mag);
                     bus.out_valid <= 1'b1;
                     state         <= DONE;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               mag_q <= mag_next;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  bus.out_data  <= apply_sign(sign_q, mag_next);
                  bus.out_valid <= 1'b1;
                  state         <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_to_fixed.sv
// Directed-vector bench for fp_to_fixed with hand-computed Q7.8 results and latencies.
module tb_fp_to_fixed;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   fp_to_fixed_if #(.FLOATSIZE(16), .FIXEDSIZE(16)) bus ();

   fp_to_fixed #(
      .FLOATSIZE     (16),
      .EXPONENTSIZE  (5),
      .EXPONENT_BIAS (15),
      .FIXEDSIZE     (16),
      .FRACBITS      (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic send(input string tag, input logic [15:0] d);
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic [15:0] ed, input logic eo, input int elat);
      int lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(elat));
      chk({tag, "_data"}, 32'(bus.out_data), 32'(ed));
      chk({tag, "_ovf"}, 32'(bus.out_overflow), 32'(eo));
      chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
   endtask

   task automatic pop(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, "_popv"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_popr"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic conv(input string tag, input logic [15:0] d, input logic [15:0] ed,
                       input logic eo, input int elat);
      send(tag, d);
      wait_result(tag, ed, eo, elat);
      pop(tag);
   endtask

   initial begin
      logic [15:0] held;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      #12;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data", 32'(bus.out_data), 32'd0);
      chk("rst_ovf", 32'(bus.out_overflow), 32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // out_ready with nothing pending must not disturb IDLE
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("idle_ordy_v", 32'(bus.out_valid), 32'd0);
      chk("idle_ordy_r", 32'(bus.in_ready), 32'd1);

      conv("one",     16'h3C00, 16'h0100, 1'b0, 3);
      conv("neg2",    16'hC000, 16'hFE00, 1'b0, 2);
      conv("trunc",   16'h3555, 16'h0055, 1'b0, 5);
      conv("four",    16'h4400, 16'h0400, 1'b0, 1);
      conv("p64",     16'h5400, 16'h4000, 1'b0, 5);
      conv("n64",     16'hD400, 16'hC000, 1'b0, 5);
      conv("lsb",     16'h1C00, 16'h0001, 1'b0, 11);
      conv("sat_p",   16'h5800, 16'h7FFF, 1'b1, 1);
      conv("sat_n",   16'hD800, 16'h8000, 1'b1, 1);
      conv("inf",     16'h7C00, 16'h7FFF, 1'b1, 1);
      conv("ninf",    16'hFC00, 16'h8000, 1'b1, 1);
      conv("zero",    16'h0000, 16'h0000, 1'b0, 1);
      conv("nzero",   16'h8000, 16'h0000, 1'b0, 1);
      conv("tiny",    16'h1400, 16'h0000, 1'b0, 1);
      conv("tiny_b",  16'h1800, 16'h0000, 1'b0, 1);

      // Stall in DONE with a new input already waiting
      send("hold", 16'h3C00);
      wait_result("hold", 16'h0100, 1'b0, 3);
      held         = bus.out_data;
      bus.in_data  = 16'h4400;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold_v", 32'(bus.out_valid), 32'd1);
         chk("hold_d", 32'(bus.out_data), 32'(held));
         chk("hold_r", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("b2b_popv", 32'(bus.out_valid), 32'd0);
      chk("b2b_notaken", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_result("b2b", 16'h0400, 1'b0, 1);
      pop("b2b");

      // Reset in the middle of a 4-cycle shift
      send("rstmid", 16'h3555);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rstmid_v", 32'(bus.out_valid), 32'd0);
      chk("rstmid_d", 32'(bus.out_data), 32'd0);
      chk("rstmid_r", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("rstmid_gone", 32'(bus.out_valid), 32'd0);
      conv("after_rst", 16'hC000, 16'hFE00, 1'b0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
